line_arbiter: RTL and testbench

LINE_ARBITER -- requirements
Module: line_arbiter

---
 rtl/adaptor_types.sv | 4 +
 rtl/arb_types.sv | 13 +
 rtl/sat_counter.sv | 31 +++
 rtl/line_arbiter.sv | 129 ++++++++++++
 tb/tb_line_arbiter.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/adaptor_types.sv
// Shared types for the cacheline adaptor interface.
package adaptor_types;
  typedef logic [255:0] line_t;
endpackage

// File: rtl/arb_types.sv
// Arbiter state encoding and address type shared by the I/D line arbiter.
package arb_types;
  localparam int ADDR_W = 32;

  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2,
    DONE  = 2'd3
  } arb_state_e;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments by one per cycle with inc_i, sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/line_arbiter.sv
// Round-robin arbiter sharing one cacheline adaptor between I and D caches.
// Request registered on the grant edge; resp and line forwarded combinationally.
module line_arbiter
  import arb_types::*;
  import adaptor_types::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,

  input  logic             i_read_i,
  input  logic [31:0]      i_addr_i,
  output line_t            i_line_o,
  output logic             i_resp_o,

  input  logic             d_read_i,
  input  logic             d_write_i,
  input  logic [31:0]      d_addr_i,
  input  line_t            d_line_i,
  output line_t            d_line_o,
  output logic             d_resp_o,

  output logic             m_read_o,
  output logic             m_write_o,
  output logic [31:0]      m_addr_o,
  output line_t            m_line_o,
  input  line_t            m_line_i,
  input  logic             m_resp_i,

  output logic [CNT_W-1:0] conflict_cnt_o
);

  arb_state_e state_q, state_d;
  logic       last_d_q, last_d_d;   // 1 when D held the most recent grant
  logic       m_read_q, m_read_d;
  logic       m_write_q, m_write_d;
  addr_t      m_addr_q, m_addr_d;
  line_t      m_line_q, m_line_d;

  logic       i_pend;
  logic       d_pend;
  logic       conflict;

  assign i_pend   = i_read_i;
  assign d_pend   = d_read_i | d_write_i;
  assign conflict = (state_q == IDLE) && i_pend && d_pend;

  always_comb begin
    state_d   = state_q;
    last_d_d  = last_d_q;
    m_read_d  = m_read_q;
    m_write_d = m_write_q;
    m_addr_d  = m_addr_q;
    m_line_d  = m_line_q;

    case (state_q)
      IDLE: begin
        // On a tie the port that did not win last time goes first.
        if (d_pend && (!i_pend || !last_d_q)) begin
          state_d   = GNT_D;
          last_d_d  = 1'b1;
          m_addr_d  = d_addr_i;
          m_line_d  = d_line_i;
          m_write_d = d_write_i;
          m_read_d  = d_read_i & ~d_write_i;
        end else if (i_pend) begin
          state_d   = GNT_I;
          last_d_d  = 1'b0;
          m_addr_d  = i_addr_i;
          m_write_d = 1'b0;
          m_read_d  = 1'b1;
        end
      end
      GNT_I, GNT_D: begin
        if (m_resp_i) begin
          state_d   = DONE;
          m_read_d  = 1'b0;
          m_write_d = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      last_d_q  <= 1'b0;
      m_read_q  <= 1'b0;
      m_write_q <= 1'b0;
      m_addr_q  <= '0;
      m_line_q  <= '0;
    end else begin
      state_q   <= state_d;
      last_d_q  <= last_d_d;
      m_read_q  <= m_read_d;
      m_write_q <= m_write_d;
      m_addr_q  <= m_addr_d;
      m_line_q  <= m_line_d;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_conflict_cnt (
    .clk     (clk),
    .rst_n   (reset_n),
    .inc_i   (conflict),
    .count_o (conflict_cnt_o)
  );

  // resp is qualified by the granted state only, so stray resp in IDLE/DONE is dropped.
  assign i_resp_o  = reset_n && m_resp_i && (state_q == GNT_I);
  assign d_resp_o  = reset_n && m_resp_i && (state_q == GNT_D);
  assign i_line_o  = m_line_i;
  assign d_line_o  = m_line_i;

  assign m_read_o  = m_read_q;
  assign m_write_o = m_write_q;
  assign m_addr_o  = m_addr_q;
  assign m_line_o  = m_line_q;

endmodule

// File: tb/tb_line_arbiter.sv
// Directed bench for line_arbiter: single grants, round-robin tie, turnaround, reset, saturation.
module tb_line_arbiter;
  import adaptor_types::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_read_i;
  logic [31:0] i_addr_i;
  logic        d_read_i;
  logic        d_write_i;
  logic [31:0] d_addr_i;
  line_t       d_line_i;
  line_t       m_line_i;
  logic        m_resp_i;

  line_t       i_line_o, d_line_o, m_line_o;
  logic        i_resp_o, d_resp_o, m_read_o, m_write_o;
  logic [31:0] m_addr_o;
  logic [15:0] conflict_cnt_o;

  line_t       s_i_line, s_d_line, s_m_line;
  logic        s_i_resp, s_d_resp, s_m_read, s_m_write;
  logic [31:0] s_m_addr;
  logic [1:0]  s_cnt;

  int vectors = 0;
  int miscompares = 0;

  line_t pat_a;
  line_t pat_b;
  line_t pat_c;

  always #5 clk = ~clk;

  line_arbiter u_dut (
    .clk(clk), .reset_n(reset_n),
    .i_read_i(i_read_i), .i_addr_i(i_addr_i), .i_line_o(i_line_o), .i_resp_o(i_resp_o),
    .d_read_i(d_read_i), .d_write_i(d_write_i), .d_addr_i(d_addr_i), .d_line_i(d_line_i),
    .d_line_o(d_line_o), .d_resp_o(d_resp_o),
    .m_read_o(m_read_o), .m_write_o(m_write_o), .m_addr_o(m_addr_o), .m_line_o(m_line_o),
    .m_line_i(m_line_i), .m_resp_i(m_resp_i),
    .conflict_cnt_o(conflict_cnt_o)
  );

  line_arbiter #(.CNT_W(2)) u_sat (
    .clk(clk), .reset_n(reset_n),
    .i_read_i(i_read_i), .i_addr_i(i_addr_i), .i_line_o(s_i_line), .i_resp_o(s_i_resp),
    .d_read_i(d_read_i), .d_write_i(d_write_i), .d_addr_i(d_addr_i), .d_line_i(d_line_i),
    .d_line_o(s_d_line), .d_resp_o(s_d_resp),
    .m_read_o(s_m_read), .m_write_o(s_m_write), .m_addr_o(s_m_addr), .m_line_o(s_m_line),
    .m_line_i(m_line_i), .m_resp_i(m_resp_i),
    .conflict_cnt_o(s_cnt)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    i_read_i  = 1'b0;
    d_read_i  = 1'b0;
    d_write_i = 1'b0;
    m_resp_i  = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    i_read_i = 1'b1; d_write_i = 1'b1; m_resp_i = 1'b1;
    i_addr_i = 32'h1234; d_addr_i = 32'h5678; d_line_i = pat_a;
    tick; tick;
    vectors++; if (m_read_o !== 1'b0) begin miscompares++; $display("FAIL rst_m_read: got %0b want 0", m_read_o); end
    vectors++; if (m_write_o !== 1'b0) begin miscompares++; $display("FAIL rst_m_write: got %0b want 0", m_write_o); end
    vectors++; if (m_addr_o !== 32'h0) begin miscompares++; $display("FAIL rst_m_addr: got %h want 0", m_addr_o); end
    vectors++; if (m_line_o !== '0) begin miscompares++; $display("FAIL rst_m_line: got %h want 0", m_line_o); end
    vectors++; if (conflict_cnt_o !== 16'd0) begin miscompares++; $display("FAIL rst_cnt: got %0d want 0", conflict_cnt_o); end
    vectors++; if (i_resp_o !== 1'b0) begin miscompares++; $display("FAIL rst_i_resp: got %0b want 0", i_resp_o); end
    vectors++; if (d_resp_o !== 1'b0) begin miscompares++; $display("FAIL rst_d_resp: got %0b want 0", d_resp_o); end
    idle_inputs;
    reset_n = 1'b1;
    tick;
  endtask

  task automatic test_i_read;
    i_read_i = 1'b1; i_addr_i = 32'h0000_0060; m_line_i = pat_a;
    #1;
    vectors++; if (i_line_o !== pat_a) begin miscompares++; $display("FAIL ir_idle_line: got %h want %h", i_line_o, pat_a); end
    vectors++; if (m_read_o !== 1'b0) begin miscompares++; $display("FAIL ir_pre_read: got %0b want 0", m_read_o); end
    tick;
    i_read_i = 1'b0; i_addr_i = 32'hFFFF_FFFF;
    vectors++; if (m_read_o !== 1'b1) begin miscompares++; $display("FAIL ir_m_read: got %0b want 1", m_read_o); end
    vectors++; if (m_write_o !== 1'b0) begin miscompares++; $display("FAIL ir_m_write: got %0b want 0", m_write_o); end
    vectors++; if (m_addr_o !== 32'h60) begin miscompares++; $display("FAIL ir_m_addr: got %h want 60", m_addr_o); end
    repeat (4) tick;
    vectors++; if (m_read_o !== 1'b1 || m_addr_o !== 32'h60) begin miscompares++; $display("FAIL ir_hold: got %0b/%h want 1/60", m_read_o, m_addr_o); end
    vectors++; if (i_resp_o !== 1'b0) begin miscompares++; $display("FAIL ir_early_resp: got %0b want 0", i_resp_o); end
    m_resp_i = 1'b1; m_line_i = pat_b;
    #1;
    vectors++; if (i_resp_o !== 1'b1) begin miscompares++; $display("FAIL ir_i_resp: got %0b want 1", i_resp_o); end
    vectors++; if (i_line_o !== pat_b) begin miscompares++; $display("FAIL ir_i_line: got %h want %h", i_line_o, pat_b); end
    vectors++; if (d_resp_o !== 1'b0) begin miscompares++; $display("FAIL ir_d_resp: got %0b want 0", d_resp_o); end
    tick;
    vectors++; if (i_resp_o !== 1'b0 || d_resp_o !== 1'b0) begin miscompares++; $display("FAIL ir_done_resp: got %0b/%0b want 0/0", i_resp_o, d_resp_o); end
    vectors++; if (m_read_o !== 1'b0) begin miscompares++; $display("FAIL ir_done_read: got %0b want 0", m_read_o); end
    m_resp_i = 1'b0;
    tick;
  endtask

  task automatic test_d_write;
    d_write_i = 1'b1; d_addr_i = 32'h8000_0020; d_line_i = pat_c;
    tick;
    d_write_i = 1'b0; d_line_i = '0; d_addr_i = 32'h0;
    vectors++; if (m_write_o !== 1'b1 || m_read_o !== 1'b0) begin miscompares++; $display("FAIL dw_rw: got w%0b r%0b want w1 r0", m_write_o, m_read_o); end
    vectors++; if (m_addr_o !== 32'h8000_0020) begin miscompares++; $display("FAIL dw_addr: got %h want 80000020", m_addr_o); end
    vectors++; if (m_line_o !== pat_c) begin miscompares++; $display("FAIL dw_line: got %h want %h", m_line_o, pat_c); end
    tick;
    vectors++; if (m_line_o !== pat_c || m_write_o !== 1'b1) begin miscompares++; $display("FAIL dw_hold: got %h/%0b want %h/1", m_line_o, m_write_o, pat_c); end
    m_resp_i = 1'b1; m_line_i = pat_a;
    #1;
    vectors++; if (d_resp_o !== 1'b1 || i_resp_o !== 1'b0) begin miscompares++; $display("FAIL dw_resp: got d%0b i%0b want d1 i0", d_resp_o, i_resp_o); end
    vectors++; if (d_line_o !== pat_a) begin miscompares++; $display("FAIL dw_d_line: got %h want %h", d_line_o, pat_a); end
    tick;
    m_resp_i = 1'b0;
    vectors++; if (m_write_o !== 1'b0) begin miscompares++; $display("FAIL dw_clear: got %0b want 0", m_write_o); end
    tick;
  endtask

  task automatic test_tie;
    reset_n = 1'b0;
    tick;
    reset_n = 1'b1;
    i_read_i = 1'b1; i_addr_i = 32'h100;
    d_read_i = 1'b1; d_addr_i = 32'h200;
    #1;
    vectors++; if (conflict_cnt_o !== 16'd0) begin miscompares++; $display("FAIL tie_cnt0: got %0d want 0", conflict_cnt_o); end
    tick;
    d_read_i = 1'b0;
    vectors++; if (m_addr_o !== 32'h200 || m_read_o !== 1'b1) begin miscompares++; $display("FAIL tie_first_d: got %h/%0b want 200/1", m_addr_o, m_read_o); end
    vectors++; if (conflict_cnt_o !== 16'd1) begin miscompares++; $display("FAIL tie_cnt1: got %0d want 1", conflict_cnt_o); end
    m_resp_i = 1'b1;
    #1;
    vectors++; if (d_resp_o !== 1'b1 || i_resp_o !== 1'b0) begin miscompares++; $display("FAIL tie_d_resp: got d%0b i%0b want d1 i0", d_resp_o, i_resp_o); end
    tick;
    m_resp_i = 1'b0;
    tick;
    tick;
    vectors++; if (m_addr_o !== 32'h100 || m_read_o !== 1'b1) begin miscompares++; $display("FAIL tie_second_i: got %h/%0b want 100/1", m_addr_o, m_read_o); end
    vectors++; if (conflict_cnt_o !== 16'd1) begin miscompares++; $display("FAIL tie_cnt_final: got %0d want 1", conflict_cnt_o); end
    m_resp_i = 1'b1;
    #1;
    vectors++; if (i_resp_o !== 1'b1 || d_resp_o !== 1'b0) begin miscompares++; $display("FAIL tie_i_resp: got i%0b d%0b want i1 d0", i_resp_o, d_resp_o); end
    tick;
    idle_inputs;
    tick;
  endtask

  task automatic test_back_to_back;
    int cyc;
    cyc = 0;
    d_read_i = 1'b1; d_addr_i = 32'h300;
    tick; cyc++;
    vectors++; if (m_read_o !== 1'b1) begin miscompares++; $display("FAIL bb_grant c%0d: got %0b want 1", cyc, m_read_o); end
    while (cyc < 10) begin
      tick; cyc++;
    end
    vectors++; if (m_read_o !== 1'b1) begin miscompares++; $display("FAIL bb_hold c%0d: got %0b want 1", cyc, m_read_o); end
    m_resp_i = 1'b1;
    #1;
    vectors++; if (d_resp_o !== 1'b1) begin miscompares++; $display("FAIL bb_resp c%0d: got %0b want 1", cyc, d_resp_o); end
    tick; cyc++;
    vectors++; if (m_read_o !== 1'b0 || d_resp_o !== 1'b0) begin miscompares++; $display("FAIL bb_done c%0d: got r%0b resp%0b want 0/0", cyc, m_read_o, d_resp_o); end
    m_resp_i = 1'b0;
    tick; cyc++;
    vectors++; if (m_read_o !== 1'b0) begin miscompares++; $display("FAIL bb_idle c%0d: got %0b want 0", cyc, m_read_o); end
    tick; cyc++;
    vectors++; if (m_read_o !== 1'b1 || m_addr_o !== 32'h300) begin miscompares++; $display("FAIL bb_regrant c%0d: got %0b/%h want 1/300", cyc, m_read_o, m_addr_o); end
    d_read_i = 1'b0;
    m_resp_i = 1'b1;
    tick;
    m_resp_i = 1'b0;
    tick;
  endtask

  task automatic test_reset_mid;
    d_write_i = 1'b1; d_addr_i = 32'h400; d_line_i = pat_b;
    tick;
    vectors++; if (m_write_o !== 1'b1) begin miscompares++; $display("FAIL rm_grant: got %0b want 1", m_write_o); end
    reset_n = 1'b0;
    #1;
    vectors++; if (m_write_o !== 1'b0 || m_addr_o !== 32'h0 || m_line_o !== '0) begin miscompares++; $display("FAIL rm_async: got w%0b a%h want w0 a0 line0", m_write_o, m_addr_o); end
    d_write_i = 1'b0;
    tick;
    reset_n = 1'b1;
    m_resp_i = 1'b1;
    #1;
    vectors++; if (d_resp_o !== 1'b0) begin miscompares++; $display("FAIL rm_no_resp: got %0b want 0", d_resp_o); end
    tick;
    vectors++; if (d_resp_o !== 1'b0 || m_write_o !== 1'b0) begin miscompares++; $display("FAIL rm_after: got resp%0b w%0b want 0/0", d_resp_o, m_write_o); end
    m_resp_i = 1'b0;
    tick;
  endtask

  task automatic test_saturate;
    reset_n = 1'b0;
    tick;
    reset_n = 1'b1;
    i_read_i = 1'b1; i_addr_i = 32'h10;
    d_read_i = 1'b1; d_addr_i = 32'h20;
    for (int k = 0; k < 5; k++) begin
      tick;
      vectors++; if (s_cnt !== 2'((k + 1 > 3) ? 3 : k + 1)) begin miscompares++; $display("FAIL sat_cnt%0d: got %0d want %0d", k, s_cnt, (k + 1 > 3) ? 3 : k + 1); end
      vectors++; if (conflict_cnt_o !== 16'(k + 1)) begin miscompares++; $display("FAIL wide_cnt%0d: got %0d want %0d", k, conflict_cnt_o, k + 1); end
      vectors++; if (m_addr_o !== ((k % 2 == 0) ? 32'h20 : 32'h10)) begin miscompares++; $display("FAIL rr_addr%0d: got %h want %h", k, m_addr_o, (k % 2 == 0) ? 32'h20 : 32'h10); end
      m_resp_i = 1'b1;
      tick;
      m_resp_i = 1'b0;
      tick;
    end
    idle_inputs;
    tick;
    vectors++; if (s_cnt !== 2'd3) begin miscompares++; $display("FAIL sat_final: got %0d want 3", s_cnt); end
  endtask

  initial begin
    pat_a = {8{32'hDEAD_BEEF}};
    pat_b = {16{16'h3C5A}};
    pat_c = {32{8'hA5}};
    idle_inputs;
    i_addr_i = '0; d_addr_i = '0; d_line_i = '0; m_line_i = '0;
    test_reset;
    test_i_read;
    test_d_write;
    test_tie;
    test_back_to_back;
    test_reset_mid;
    test_saturate;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
